datapath_unit: RTL and testbench

16-bit processor datapath joining a 16×16 register file, an 8-function ALU, a 256×16 single-port data memory and a 16-bit 2:1 write-back mux. It sits under the control unit, which decodes instructions and supplies every select, enable and address. The block holds no instruction state; it executes one register-transfer per clock as commanded.

---
 rtl/datapath_pkg.sv | 30 +++
 rtl/datapath_unit_if.sv | 57 +++++
 rtl/datapath_unit_alu16.sv | 32 +++
 rtl/datapath_unit.sv | 88 ++++++++
 tb/tb_datapath_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared width constants and the ALU function encoding for the 16-bit
// datapath slice (datapath_unit, alu16, datapath_unit_if).
//   DATA_W  : register / memory data width
//   DADDR_W : data-memory address width (256 words)
//   RADDR_W : register-file address width (16 registers)
//   RSEL_W  : ALU function select width
// -----------------------------------------------------------------------------
package datapath_pkg;

    localparam int DATA_W  = 16;
    localparam int DADDR_W = 8;
    localparam int RADDR_W = 4;
    localparam int RSEL_W  = 3;
    localparam int NREGS   = 1 << RADDR_W;
    localparam int NWORDS  = 1 << DADDR_W;

    typedef enum logic [RSEL_W-1:0] {
        ALU_ZERO   = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_PASS_A = 3'd3,
        ALU_XOR    = 3'd4,
        ALU_OR     = 3'd5,
        ALU_AND    = 3'd6,
        ALU_INC    = 3'd7
    } alu_op_t;

endpackage

// File: rtl/datapath_unit_if.sv
// -----------------------------------------------------------------------------
// datapath_unit_if
// Control/observation bundle between the control unit and datapath_unit.
//
// Protocol: there is no valid/ready handshake. The controller presents one
// register-transfer command per clock (selects, enables, addresses); it is
// acted on at the next rising edge. ALU_A_out / ALU_B_out / ALUout are
// combinational views of the current command and are always valid.
//
// Signals (controller -> datapath):
//   ALU_s0[2:0] ALU function, D_addr[7:0] memory address, D_wr memory write,
//   RF_sel write-back select (0 ALU, 1 memory), RF_W_en register write,
//   WriteAddr/rdAddrA/rdAddrB[3:0] register addresses.
// Signals (datapath -> controller):
//   ALU_A_out, ALU_B_out, ALUout [15:0]; ALU_zero when DATAPATH_ZERO_FLAG_EN
//   is defined.
// Modports: master = control unit / testbench, slave = datapath_unit.
// -----------------------------------------------------------------------------
interface datapath_unit_if;
    import datapath_pkg::*;

    logic [RSEL_W-1:0]  ALU_s0;
    logic [DADDR_W-1:0] D_addr;
    logic               D_wr;
    logic               RF_sel;
    logic               RF_W_en;
    logic [RADDR_W-1:0] WriteAddr;
    logic [RADDR_W-1:0] rdAddrA;
    logic [RADDR_W-1:0] rdAddrB;
    logic [DATA_W-1:0]  ALU_A_out;
    logic [DATA_W-1:0]  ALU_B_out;
    logic [DATA_W-1:0]  ALUout;
`ifdef DATAPATH_ZERO_FLAG_EN
    logic               ALU_zero;
`endif

`ifdef DATAPATH_ZERO_FLAG_EN
    modport master (
        output ALU_s0, D_addr, D_wr, RF_sel, RF_W_en, WriteAddr, rdAddrA, rdAddrB,
        input  ALU_A_out, ALU_B_out, ALUout, ALU_zero
    );
    modport slave (
        input  ALU_s0, D_addr, D_wr, RF_sel, RF_W_en, WriteAddr, rdAddrA, rdAddrB,
        output ALU_A_out, ALU_B_out, ALUout, ALU_zero
    );
`else
    modport master (
        output ALU_s0, D_addr, D_wr, RF_sel, RF_W_en, WriteAddr, rdAddrA, rdAddrB,
        input  ALU_A_out, ALU_B_out, ALUout
    );
    modport slave (
        input  ALU_s0, D_addr, D_wr, RF_sel, RF_W_en, WriteAddr, rdAddrA, rdAddrB,
        output ALU_A_out, ALU_B_out, ALUout
    );
`endif

endinterface

// File: rtl/datapath_unit_alu16.sv
// -----------------------------------------------------------------------------
// alu16
// Purely combinational 16-bit ALU. All arithmetic wraps modulo 2^16, no flags.
//   op [2:0] : function (alu_op_t)
//   a, b     : operands
//   y        : result
// -----------------------------------------------------------------------------
module alu16
    import datapath_pkg::*;
(
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ZERO:   y = '0;
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_PASS_A: y = a;
            ALU_XOR:    y = a ^ b;
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_INC:    y = a + 16'd1;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/datapath_unit.sv
// -----------------------------------------------------------------------------
// datapath_unit
// 16-bit datapath: 16x16 register file (2 combinational read ports, 1 write
// port), alu16, 256x16 single-port data memory with registered read data,
// and a 2:1 write-back mux. Executes one register-transfer per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (registers and memory read data)
//   bus : datapath_unit_if.slave, control in / operand and result out
// Optional: define DATAPATH_ZERO_FLAG_EN to drive bus.ALU_zero = (ALUout==0).
// -----------------------------------------------------------------------------
module datapath_unit
    import datapath_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    datapath_unit_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] mem_q  [NWORDS];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] wb_data;

    // Register file reads are combinational, so a same-cycle read of the
    // write address sees the old value until the edge.
    assign a_data = regs_q[bus.rdAddrA];
    assign b_data = regs_q[bus.rdAddrB];

    alu16 u_alu (
        .op (alu_op_t'(bus.ALU_s0)),
        .a  (a_data),
        .b  (b_data),
        .y  (alu_y)
    );

    assign wb_data = bus.RF_sel ? rd_q : alu_y;

    always_comb begin
        regs_d = regs_q;
        if (bus.RF_W_en) begin
            regs_d[bus.WriteAddr] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Store data always comes from port A. Array contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.D_wr) begin
            mem_q[bus.D_addr] <= a_data;
        end
    end

    // Registered read data; on a write it shows the new data (write-through),
    // so a load issued right after a store returns the stored value.
    always_comb begin
        rd_d = bus.D_wr ? a_data : mem_q[bus.D_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign bus.ALU_A_out = a_data;
    assign bus.ALU_B_out = b_data;
    assign bus.ALUout    = alu_y;
`ifdef DATAPATH_ZERO_FLAG_EN
    assign bus.ALU_zero  = (alu_y == '0);
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// -----------------------------------------------------------------------------
// tb_datapath_unit
// Directed bench for datapath_unit: reset state, constant build, subtract
// wrap, store/load timing, logic ops, register 0 writes, async reset abort.
// -----------------------------------------------------------------------------
module tb_datapath_unit;
    import datapath_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    datapath_unit_if bus ();

    datapath_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed only here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.RF_W_en = 1'b0;
        bus.D_wr    = 1'b0;
        bus.RF_sel  = 1'b0;
    endtask

    // Read a register through port B (enables must be off).
    task automatic rd_check(input string tag, input int idx, input logic [15:0] exp);
        bus.rdAddrB = idx[3:0];
        #1;
        check(tag, bus.ALU_B_out, exp);
    endtask

    task automatic set_op(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb);
        bus.ALU_s0  = op;
        bus.rdAddrA = ra;
        bus.rdAddrB = rb;
    endtask

    initial begin
        rst = 1'b1;
        bus.ALU_s0 = 3'd1; bus.D_addr = 8'hFF; bus.D_wr = 1'b0; bus.RF_sel = 1'b0;
        bus.RF_W_en = 1'b0; bus.WriteAddr = 4'd0; bus.rdAddrA = 4'd0; bus.rdAddrB = 4'd0;
        tick();
        tick();

        // Reset state.
        check("rst_a", bus.ALU_A_out, 16'h0000);
        check("rst_b", bus.ALU_B_out, 16'h0000);
        check("rst_aluout_add", bus.ALUout, 16'h0000);
        bus.ALU_s0 = 3'd7;
        #1;
        check("rst_aluout_inc", bus.ALUout, 16'h0001);
        for (int i = 0; i < 16; i++) rd_check($sformatf("rst_reg%0d", i), i, 16'h0000);
        rst = 1'b0;
        tick();

        // R1 = R0 + 1; same-cycle read of R1 still returns old value.
        set_op(3'd7, 4'd0, 4'd1);
        bus.WriteAddr = 4'd1; bus.RF_W_en = 1'b1;
        #1;
        check("inc_r0", bus.ALUout, 16'h0001);
        check("r1_old_before_edge", bus.ALU_B_out, 16'h0000);
        tick();
        idle();
        rd_check("r1", 1, 16'h0001);

        // R2 = R1 + 1.
        set_op(3'd7, 4'd1, 4'd0);
        bus.WriteAddr = 4'd2; bus.RF_W_en = 1'b1;
        #1;
        check("inc_r1", bus.ALUout, 16'h0002);
        tick();
        idle();
        rd_check("r2", 2, 16'h0002);

        // R3 = R1 + R2.
        set_op(3'd1, 4'd1, 4'd2);
        bus.WriteAddr = 4'd3; bus.RF_W_en = 1'b1;
        #1;
        check("add_r1_r2", bus.ALUout, 16'h0003);
        tick();
        idle();
        rd_check("r3", 3, 16'h0003);

        // R9 = R1 - R2 wraps; R9 + R1 wraps back to zero.
        set_op(3'd2, 4'd1, 4'd2);
        bus.WriteAddr = 4'd9; bus.RF_W_en = 1'b1;
        #1;
        check("sub_wrap", bus.ALUout, 16'hFFFF);
        tick();
        idle();
        rd_check("r9", 9, 16'hFFFF);
        set_op(3'd1, 4'd9, 4'd1);
        #1;
        check("add_wrap", bus.ALUout, 16'h0000);
`ifdef DATAPATH_ZERO_FLAG_EN
        check("zero_flag_set", {15'd0, bus.ALU_zero}, 16'h0001);
`endif

        // STORE R3 -> mem[0xFF].
        bus.ALU_s0 = 3'd0; bus.rdAddrA = 4'd3; bus.D_addr = 8'hFF; bus.D_wr = 1'b1;
        tick();
        // Write-through: the very next cycle's write-back sees the stored value.
        idle();
        bus.RF_sel = 1'b1; bus.RF_W_en = 1'b1; bus.WriteAddr = 4'd5;
        tick();
        idle();
        rd_check("r5_write_through", 5, 16'h0003);

        // Two-cycle LOAD mem[0xFF] -> R4.
        bus.D_addr = 8'hFF;
        tick();
        bus.RF_sel = 1'b1; bus.RF_W_en = 1'b1; bus.WriteAddr = 4'd4;
        tick();
        idle();
        rd_check("r4_load", 4, 16'h0003);

        // Early write-back to an unwritten address gets the stale q (from 0xFF).
        bus.D_addr = 8'h10; bus.RF_sel = 1'b1; bus.RF_W_en = 1'b1; bus.WriteAddr = 4'd6;
        tick();
        idle();
        bus.D_addr = 8'hFF;
        rd_check("r6_stale_q", 6, 16'h0003);

        // Logic ops with A=R3=3, B=R2=2.
        set_op(3'd4, 4'd3, 4'd2); #1; check("xor", bus.ALUout, 16'h0001);
`ifdef DATAPATH_ZERO_FLAG_EN
        check("zero_flag_clr", {15'd0, bus.ALU_zero}, 16'h0000);
`endif
        set_op(3'd5, 4'd3, 4'd2); #1; check("or", bus.ALUout, 16'h0003);
        set_op(3'd6, 4'd3, 4'd2); #1; check("and", bus.ALUout, 16'h0002);
        set_op(3'd3, 4'd3, 4'd2); #1; check("pass_a", bus.ALUout, 16'h0003);
        set_op(3'd0, 4'd3, 4'd2); #1; check("zero_op", bus.ALUout, 16'h0000);
        set_op(3'd2, 4'd3, 4'd2); #1; check("sub_3_2", bus.ALUout, 16'h0001);
        set_op(3'd7, 4'd3, 4'd2); #1; check("inc_3", bus.ALUout, 16'h0004);
        check("port_a_r3", bus.ALU_A_out, 16'h0003);

        // Register 0 is writable: R0 = R1 + 1 = 2.
        set_op(3'd7, 4'd1, 4'd0);
        bus.WriteAddr = 4'd0; bus.RF_W_en = 1'b1;
        tick();
        idle();
        rd_check("r0_written", 0, 16'h0002);

        // Async reset in the middle of a load: address cycle, then reset pulse.
        bus.D_addr = 8'hFF;
        tick();
        bus.rdAddrA = 4'd3;
        #1 rst = 1'b1;
        #1;
        check("async_r3", bus.ALU_A_out, 16'h0000);
        rd_check("async_r0", 0, 16'h0000);
        rd_check("async_r9", 9, 16'h0000);
        rst = 1'b0;
        // Second half of the aborted load: q was cleared, R7 stays 0.
        bus.RF_sel = 1'b1; bus.RF_W_en = 1'b1; bus.WriteAddr = 4'd7;
        tick();
        idle();
        rd_check("aborted_load_r7", 7, 16'h0000);

        // Memory survived reset: reload 0xFF into R7.
        bus.D_addr = 8'hFF;
        tick();
        bus.RF_sel = 1'b1; bus.RF_W_en = 1'b1; bus.WriteAddr = 4'd7;
        tick();
        idle();
        rd_check("reload_r7", 7, 16'h0003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
